// File: rtl/sum3_pkg.sv
// Shared widths and types for the three-operand adder datapath.
package sum3_pkg;

  localparam int IN_W  = 12;
  localparam int OUT_W = IN_W + 2;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [OUT_W-1:0] sum_t;

endpackage

// File: rtl/module_top_sum3_csa_3to2.sv
// Combinational 3:2 carry-save compressor: per-bit sum and majority carry.
module csa_3to2 #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_k
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_k = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/module_top_sum3.sv
// Registered three-operand unsigned adder: capture on e, sum one edge later.
module module_top_sum3 #(
  parameter int IN_W = sum3_pkg::IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic [IN_W-1:0]  c,
  input  logic             e,
  output logic [IN_W+1:0]  y
);

  localparam int OUT_W = IN_W + 2;

  import sum3_pkg::*;

  logic [IN_W-1:0]  r_a_p0;
  logic [IN_W-1:0]  r_b_p0;
  logic [IN_W-1:0]  r_c_p0;
  logic [IN_W-1:0]  w_s;
  logic [IN_W-1:0]  w_k;
  logic [OUT_W-1:0] w_sum;

  // Stage 0: operand capture, held while e is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
      r_c_p0 <= '0;
    end else if (e) begin
      r_a_p0 <= a;
      r_b_p0 <= b;
      r_c_p0 <= c;
    end
  end

  csa_3to2 #(
    .W (IN_W)
  ) u_csa (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .i_c (r_c_p0),
    .o_s (w_s),
    .o_k (w_k)
  );

  // Carry vector carries weight 2, so it enters the CPA shifted left by one
  assign w_sum = {2'b00, w_s} + {1'b0, w_k, 1'b0};

  // Stage 1: output register, updated every edge regardless of e
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= w_sum;
    end
  end

endmodule

// File: tb/tb_module_top_sum3.sv
// Scoreboard bench for module_top_sum3 with a held-operand reference model.
module tb_module_top_sum3;
  import sum3_pkg::*;

  logic     clk;
  logic     rst_n;
  operand_t a, b, c;
  logic     e;
  sum_t     y;

  int n_cmp;
  int n_bad;

  int   m_a, m_b, m_c;   // operands the reference believes are held
  int   exp_q[$];

  module_top_sum3 #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .e     (e),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: y=%0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Issue one cycle of stimulus; expected y after the coming edge is the sum held before it.
  task automatic cycle(input int ia, input int ib, input int ic, input bit ie);
    @(negedge clk);
    a = operand_t'(ia);
    b = operand_t'(ib);
    c = operand_t'(ic);
    e = ie;
    exp_q.push_back(m_a + m_b + m_c);
    if (ie) begin
      m_a = ia;
      m_b = ib;
      m_c = ic;
    end
  endtask

  task automatic rand_cycle(input bit ie);
    cycle($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), ie);
  endtask

  // Assert reset between edges, check y clears at once and stays clear.
  task automatic reset_mid(input string name, input int hold_cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "_async"}, int'(y), 0);
    m_a = 0;
    m_b = 0;
    m_c = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      a = operand_t'($urandom_range(0, 4095));
      b = operand_t'($urandom_range(0, 4095));
      c = operand_t'($urandom_range(0, 4095));
      e = 1'b1;
      #1;
      check({name, "_held"}, int'(y), 0);
    end
    @(negedge clk);
    e = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: y updates every edge, so one expectation is consumed per edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("scoreboard", int'(y), exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_a = 0; m_b = 0; m_c = 0;
    rst_n = 1'b0;
    e = 1'b1;
    a = operand_t'($urandom_range(0, 4095));
    b = operand_t'($urandom_range(0, 4095));
    c = operand_t'($urandom_range(0, 4095));
    #1;
    check("reset_initial", int'(y), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = operand_t'($urandom_range(0, 4095));
      #1;
      check("reset_hold", int'(y), 0);
    end
    @(negedge clk);
    e = 1'b0;
    rst_n = 1'b1;

    // Basic capture then hold with changing operands
    cycle(12'hDFC, 12'h5B4, 12'h0E7, 1'b1);
    for (int i = 0; i < 5; i++) cycle(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
    @(negedge clk);
    check("hold_direct", int'(y), 14'h1497);
    cycle(12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
    cycle(0, 0, 0, 1'b0);
    cycle(0, 0, 0, 1'b0);
    check("max_direct", int'(y), 14'h2FFD);

    // Enable toggling 1,1,0,1,0,1 with fresh operands every cycle
    rand_cycle(1'b1);
    rand_cycle(1'b1);
    rand_cycle(1'b0);
    rand_cycle(1'b1);
    rand_cycle(1'b0);
    rand_cycle(1'b1);
    rand_cycle(1'b0);

    // Boundary operands
    cycle(0, 0, 0, 1'b1);
    cycle(12'hFFF, 0, 0, 1'b1);
    cycle(12'hFFF, 12'hFFF, 0, 1'b1);
    cycle(0, 12'hFFF, 12'hFFF, 1'b1);
    cycle(12'hAAA, 12'h555, 12'hFFF, 1'b1);
    cycle(0, 0, 0, 1'b0);

    // Random traffic with random enable
    for (int i = 0; i < 300; i++) rand_cycle(1'($urandom_range(0, 1)));

    // Reset mid-operation while y shows 0x1497
    cycle(12'hDFC, 12'h5B4, 12'h0E7, 1'b1);
    cycle(0, 0, 0, 1'b0);
    @(negedge clk);
    check("pre_reset_direct", int'(y), 14'h1497);
    reset_mid("reset_mid", 3);
    cycle(0, 0, 0, 1'b0);
    cycle(1, 2, 3, 1'b1);
    cycle(0, 0, 0, 1'b0);
    cycle(0, 0, 0, 1'b0);
    check("post_reset_direct", int'(y), 6);

    for (int i = 0; i < 50; i++) rand_cycle(1'($urandom_range(0, 1)));

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
